// File: rtl/simon_pkg.sv
// Shared types for the Simon game and its automatic responder.
package simon_pkg;

  typedef enum logic [2:0] {
    G_INIT,
    G_SHOW,
    G_WAIT,
    G_SCORE,
    G_OVER
  } game_state_t;

  typedef enum logic [2:0] {
    IDLE,
    REACT,
    PRESS1,
    PRESS2,
    HOLD,
    RELEASE
  } resp_state_t;

  localparam int PB_W = 20;
  localparam logic [3:0] ANSWERED_MAX = 4'd15;

  // The timer counts down to zero inclusive, so it is loaded with duration-1;
  // a zero duration is treated as one cycle.
  function automatic logic [7:0] dur_m1(input logic [7:0] cyc);
    return (cyc == 8'd0) ? 8'd0 : cyc - 8'd1;
  endfunction

  function automatic logic [PB_W-1:0] onehot_pb(input logic [3:0] idx);
    return {{(PB_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/simon_responder_if.sv
// Challenge/response signal bundle between the Simon game and the responder.
interface simon_responder_if;
  logic        en;
  logic        start;
  logic [11:0] btns;
  logic        simon_says;
  logic [19:0] pb;
  logic        busy;
  logic        done;
  logic [3:0]  answered;

  modport master (
    output en, start, btns, simon_says,
    input  pb, busy, done, answered
  );

  modport slave (
    input  en, start, btns, simon_says,
    output pb, busy, done, answered
  );
endinterface

// File: rtl/simon_responder_cyc_timer.sv
// 8-bit loadable down-counter with a zero flag; times every responder state.
module cyc_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/simon_responder.sv
// Automatic Simon responder: after a reaction delay presses the three
// challenge buttons one by one, holds them together, then releases.
module simon_responder
  import simon_pkg::*;
#(
  parameter logic [7:0] REACT_CYC = 8'd20,
  parameter logic [7:0] STEP_CYC  = 8'd4,
  parameter logic [7:0] HOLD_CYC  = 8'd10
) (
  input  logic                clk,
  input  logic                rst,
  simon_responder_if.slave    bus
);

  resp_state_t     state_q, state_d;
  logic [11:0]     btns_q, btns_d;
  logic            ss_q, ss_d;
  logic [PB_W-1:0] pb_q, pb_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [3:0]      answered_q, answered_d;

  logic            tmr_load;
  logic [7:0]      tmr_val;
  logic            tmr_dec;
  logic            tmr_zero;

  cyc_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  logic [PB_W-1:0] oh0, oh1, oh2;

  always_comb begin
    state_d    = state_q;
    btns_d     = btns_q;
    ss_d       = ss_q;
    answered_d = answered_q;
    tmr_load   = 1'b0;
    tmr_val    = 8'd0;

    if ((state_q != IDLE) && !bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && bus.en) begin
            state_d  = REACT;
            btns_d   = bus.btns;
            ss_d     = bus.simon_says;
            tmr_load = 1'b1;
            tmr_val  = dur_m1(REACT_CYC);
          end
        end
        REACT: begin
          if (tmr_zero) begin
            if (ss_q) begin
              state_d  = PRESS1;
              tmr_load = 1'b1;
              tmr_val  = dur_m1(STEP_CYC);
            end else begin
              state_d = RELEASE;
            end
          end
        end
        PRESS1: begin
          if (tmr_zero) begin
            state_d  = PRESS2;
            tmr_load = 1'b1;
            tmr_val  = dur_m1(STEP_CYC);
          end
        end
        PRESS2: begin
          if (tmr_zero) begin
            state_d    = HOLD;
            tmr_load   = 1'b1;
            tmr_val    = dur_m1(HOLD_CYC);
            answered_d = (answered_q == ANSWERED_MAX) ? answered_q : answered_q + 4'd1;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    tmr_dec = !tmr_load;

    // Outputs are derived from the next state so they register alongside it.
    oh0 = onehot_pb(btns_d[3:0]);
    oh1 = onehot_pb(btns_d[7:4]);
    oh2 = onehot_pb(btns_d[11:8]);
    case (state_d)
      PRESS1:  pb_d = oh0;
      PRESS2:  pb_d = oh0 | oh1;
      HOLD:    pb_d = oh0 | oh1 | oh2;
      default: pb_d = '0;
    endcase
    done_d = (state_d == RELEASE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      btns_q     <= 12'd0;
      ss_q       <= 1'b0;
      pb_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      answered_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      btns_q     <= btns_d;
      ss_q       <= ss_d;
      pb_q       <= pb_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      answered_q <= answered_d;
    end
  end

  assign bus.pb       = pb_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.answered = answered_q;

endmodule

// File: tb/tb_simon_responder.sv
// Randomised self-checking bench: two responders (default and zero/one
// durations) compared cycle by cycle against a phase-arithmetic model.
module tb_simon_responder;

  localparam int RA = 20, SA = 4, HA = 10;
  localparam int RB = 0,  SB = 1, HB = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        start_b = 1'b0;
  logic        ss = 1'b0;
  logic [11:0] btns = 12'd0;

  simon_responder_if bus_a();
  simon_responder_if bus_b();

  assign bus_a.en         = en;
  assign bus_a.start      = start;
  assign bus_a.btns       = btns;
  assign bus_a.simon_says = ss;
  assign bus_b.en         = en;
  assign bus_b.start      = start_b;
  assign bus_b.btns       = btns;
  assign bus_b.simon_says = ss;

  simon_responder #(.REACT_CYC(8'(RA)), .STEP_CYC(8'(SA)), .HOLD_CYC(8'(HA))) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  simon_responder #(.REACT_CYC(8'(RB)), .STEP_CYC(8'(SB)), .HOLD_CYC(8'(HB))) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ans_a = 0;
  int ans_b = 0;

  typedef struct packed {
    logic [19:0] pb;
    logic        busy;
    logic        done;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int eff(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic logic [19:0] press(input logic [3:0] idx);
    logic [19:0] v;
    v = 20'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Expected outputs at sample k (k=1 is the cycle after the start edge).
  function automatic exp_t model(input int k, input int r_p, input int s_p, input int h_p,
                                 input logic [11:0] b, input logic s, input int drop_k);
    exp_t e;
    int r, st, h;
    logic [19:0] p0, p01, p012;
    r = eff(r_p); st = eff(s_p); h = eff(h_p);
    p0   = press(b[3:0]);
    p01  = p0 | press(b[7:4]);
    p012 = p01 | press(b[11:8]);
    e = '0;
    if (drop_k > 0 && k > drop_k) return e;
    if (!s) begin
      if (k <= r) e.busy = 1'b1;
      else if (k == r + 1) begin e.busy = 1'b1; e.done = 1'b1; end
    end else begin
      if (k <= r)                  e.busy = 1'b1;
      else if (k <= r + st)        begin e.busy = 1'b1; e.pb = p0;   end
      else if (k <= r + 2*st)      begin e.busy = 1'b1; e.pb = p01;  end
      else if (k <= r + 2*st + h)  begin e.busy = 1'b1; e.pb = p012; end
      else if (k == r + 2*st + h + 1) begin e.busy = 1'b1; e.done = 1'b1; end
    end
    return e;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_outs(input string nm, input int k, input exp_t e, input int ans,
                            input logic [19:0] pb, input logic busy, input logic done,
                            input logic [3:0] answered);
    chk($sformatf("%s.pb k=%0d", nm, k), 32'(pb), 32'(e.pb));
    chk($sformatf("%s.busy k=%0d", nm, k), 32'(busy), 32'(e.busy));
    chk($sformatf("%s.done k=%0d", nm, k), 32'(done), 32'(e.done));
    chk($sformatf("%s.answered k=%0d", nm, k), 32'(answered), 32'(ans));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a.pb"}, 32'(bus_a.pb), 32'd0);
    chk({tag, ".a.busy"}, 32'(bus_a.busy), 32'd0);
    chk({tag, ".a.done"}, 32'(bus_a.done), 32'd0);
    chk({tag, ".a.answered"}, 32'(bus_a.answered), 32'd0);
    chk({tag, ".b.busy"}, 32'(bus_b.busy), 32'd0);
    chk({tag, ".b.answered"}, 32'(bus_b.answered), 32'd0);
  endtask

  // One challenge; rep_k re-pulses start (hostile btns), drop_k lowers en,
  // rst_k pulls reset -- each right after sample k.
  task automatic run_txn(input int id, input logic [11:0] b, input logic s,
                         input int drop_k, input int rep_k, input int rst_k);
    int   len, hold_a, hold_b;
    logic got_a, got_b;
    exp_t ea, eb;
    len    = s ? eff(RA) + 2*eff(SA) + eff(HA) + 1 : eff(RA) + 1;
    hold_a = eff(RA) + 2*eff(SA) + 1;
    hold_b = eff(RB) + 2*eff(SB) + 1;
    got_a  = s && (drop_k == 0 || drop_k >= hold_a) && (rst_k == 0 || rst_k >= hold_a);
    got_b  = s && (drop_k == 0 || drop_k >= hold_b) && (rst_k == 0 || rst_k >= hold_b);
    btns = b; ss = s; start = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
    for (int k = 1; k <= len + 2; k++) begin
      ea = model(k, RA, SA, HA, b, s, drop_k);
      eb = model(k, RB, SB, HB, b, s, drop_k);
      check_outs($sformatf("t%0d.a", id), k, ea, sat15(ans_a + ((got_a && k >= hold_a) ? 1 : 0)),
                 bus_a.pb, bus_a.busy, bus_a.done, bus_a.answered);
      check_outs($sformatf("t%0d.b", id), k, eb, sat15(ans_b + ((got_b && k >= hold_b) ? 1 : 0)),
                 bus_b.pb, bus_b.busy, bus_b.done, bus_b.answered);
      if (k == rst_k) begin
        rst = 1'b0;
        #1;
        check_zero($sformatf("t%0d.rst_now", id));
        @(posedge clk); #1;
        check_zero($sformatf("t%0d.rst_held", id));
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero($sformatf("t%0d.rst_after", id));
        break;
      end
      start = (k == rep_k);
      btns  = (k == rep_k) ? 12'hFFF : b;
      ss    = (k == rep_k) ? ~s : s;
      if (k == drop_k) en = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    en    = 1'b1;
    if (rst_k != 0) begin
      ans_a = 0;
      ans_b = 0;
    end else begin
      ans_a = sat15(ans_a + (got_a ? 1 : 0));
      ans_b = sat15(ans_b + (got_b ? 1 : 0));
    end
    $display("txn %0d btns=%03h ss=%0d drop=%0d repulse=%0d rst=%0d answered=%0d/%0d",
             id, b, s, drop_k, rep_k, rst_k, bus_a.answered, bus_b.answered);
  endtask

  task automatic blocked_start(input int id);
    en = 1'b0; btns = 12'h521; ss = 1'b1; start = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("t%0d.en_low.a.busy k=%0d", id, k), 32'(bus_a.busy), 32'd0);
      chk($sformatf("t%0d.en_low.b.busy k=%0d", id, k), 32'(bus_b.busy), 32'd0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    $display("txn %0d start with en low, busy=%0d/%0d", id, bus_a.busy, bus_b.busy);
  endtask

  initial begin
    int id;
    int dk, rk;
    logic s;
    #12;
    check_zero("reset");
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 12'h521, 1'b1, 0, 0, 0);
    run_txn(1, 12'h521, 1'b0, 0, 0, 0);
    run_txn(2, 12'h333, 1'b1, 0, 0, 0);
    run_txn(3, 12'h521, 1'b1, 0, 10, 0);
    run_txn(4, 12'h521, 1'b1, 30, 0, 0);
    run_txn(5, 12'h521, 1'b1, 0, 0, 25);
    blocked_start(6);

    id = 7;
    for (int n = 0; n < 40; n++) begin
      s  = ($urandom_range(0, 3) != 0);
      dk = 0;
      rk = 0;
      if ($urandom_range(0, 4) == 0) dk = $urandom_range(1, s ? 39 : 21);
      else if ($urandom_range(0, 2) == 0) rk = $urandom_range(2, s ? 39 : 21);
      run_txn(id, 12'($urandom), s, dk, rk, 0);
      id++;
    end

    for (int n = 0; n < 16; n++) begin
      run_txn(id, 12'($urandom), 1'b1, 0, 0, 0);
      id++;
    end
    chk("saturate.a", 32'(bus_a.answered), 32'd15);
    chk("saturate.b", 32'(bus_b.answered), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
